hash_cam_core: RTL and testbench

HASH_CAM_CORE -- requirements
Module: hash_cam_core

---
 rtl/hash_cam_core.sv | 182 ++++++++++++++++++
 tb/tb_hash_cam_core.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/hash_cam_core.sv
// Hash-indexed CAM: 16-bit keys to 8-bit values, linear probing, one slot examined per cycle.
// Optional HASHCAM_CLEAR_EN macro adds an HC_clear port that empties the table in a single idle cycle.
module hash_cam_core #(
  parameter int unsigned INDEX_W = 4
) (
  input  logic       clk,
  input  logic       reset,
`ifdef HASHCAM_CLEAR_EN
  input  logic       HC_clear,
`endif
  input  logic       HC_write_enable,
  output logic       HC_write_ready,
  input  logic       HC_lookup_enable,
  output logic       HC_lookup_ready,
  input  logic [15:0] HC_key_in,
  input  logic [7:0]  HC_value_in,
  output logic       HC_match,
  output logic [7:0] HC_value_out,
  output logic       HC_full
);

  localparam int unsigned DEPTH  = 1 << INDEX_W;
  localparam int unsigned NCHUNK = (16 + INDEX_W - 1) / INDEX_W;

  typedef enum logic [1:0] {IDLE, WPROBE, LPROBE} state_t;

  state_t               state_q, state_d;
  logic                 ready_q, ready_d;
  logic [15:0]          op_key_q, op_key_d;
  logic [7:0]           op_val_q, op_val_d;
  logic [INDEX_W-1:0]   probe_q, probe_d;
  logic [DEPTH-1:0]     valid_q, valid_d;
  logic [15:0]          tkey_q [DEPTH];
  logic [15:0]          tkey_d [DEPTH];
  logic [7:0]           tval_q [DEPTH];
  logic [7:0]           tval_d [DEPTH];
  logic [INDEX_W:0]     occ_q, occ_d;
  logic                 full_q, full_d;
  logic                 match_q, match_d;
  logic [7:0]           vout_q, vout_d;

  logic [INDEX_W-1:0]   hash;
  logic [INDEX_W-1:0]   slot;
  logic [23:0]          key_ext;
  logic                 slot_hit;
  logic                 last_probe;

  // Shifting a zero-extended key gives the zero-padded top chunk for free.
  always_comb begin
    key_ext = {8'h00, op_key_q};
    hash    = '0;
    for (int unsigned c = 0; c < NCHUNK; c++) begin
      hash = hash ^ INDEX_W'(key_ext >> (c * INDEX_W));
    end
  end

  assign slot       = hash + probe_q;
  assign slot_hit   = valid_q[slot] && (tkey_q[slot] == op_key_q);
  assign last_probe = (probe_q == '1);

  always_comb begin
    state_d  = state_q;
    ready_d  = ready_q;
    op_key_d = op_key_q;
    op_val_d = op_val_q;
    probe_d  = probe_q;
    valid_d  = valid_q;
    tkey_d   = tkey_q;
    tval_d   = tval_q;
    occ_d    = occ_q;
    full_d   = full_q;
    match_d  = match_q;
    vout_d   = vout_q;

    case (state_q)
      IDLE: begin
        if (!ready_q) begin
          ready_d = 1'b1;
        end else
`ifdef HASHCAM_CLEAR_EN
        if (HC_clear) begin
          valid_d = '0;
          occ_d   = '0;
          full_d  = 1'b0;
        end else
`endif
        if (HC_write_enable) begin
          state_d  = WPROBE;
          ready_d  = 1'b0;
          op_key_d = HC_key_in;
          op_val_d = HC_value_in;
          probe_d  = '0;
        end else if (HC_lookup_enable) begin
          state_d  = LPROBE;
          ready_d  = 1'b0;
          op_key_d = HC_key_in;
          op_val_d = HC_value_in;
          probe_d  = '0;
        end
      end

      WPROBE: begin
        if (slot_hit) begin
          tval_d[slot] = op_val_q;
          state_d      = IDLE;
          ready_d      = 1'b1;
        end else if (!valid_q[slot]) begin
          valid_d[slot] = 1'b1;
          tkey_d[slot]  = op_key_q;
          tval_d[slot]  = op_val_q;
          occ_d         = occ_q + 1'b1;
          full_d        = (occ_q == (INDEX_W + 1)'(DEPTH - 1));
          state_d       = IDLE;
          ready_d       = 1'b1;
        end else if (last_probe) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end else begin
          probe_d = probe_q + 1'b1;
        end
      end

      LPROBE: begin
        if (slot_hit) begin
          match_d = 1'b1;
          vout_d  = tval_q[slot];
          state_d = IDLE;
          ready_d = 1'b1;
        end else if (!valid_q[slot] || last_probe) begin
          match_d = 1'b0;
          vout_d  = 8'h00;
          state_d = IDLE;
          ready_d = 1'b1;
        end else begin
          probe_d = probe_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ready_q  <= 1'b0;
      op_key_q <= '0;
      op_val_q <= '0;
      probe_q  <= '0;
      valid_q  <= '0;
      tkey_q   <= '{default: '0};
      tval_q   <= '{default: '0};
      occ_q    <= '0;
      full_q   <= 1'b0;
      match_q  <= 1'b0;
      vout_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      op_key_q <= op_key_d;
      op_val_q <= op_val_d;
      probe_q  <= probe_d;
      valid_q  <= valid_d;
      tkey_q   <= tkey_d;
      tval_q   <= tval_d;
      occ_q    <= occ_d;
      full_q   <= full_d;
      match_q  <= match_d;
      vout_q   <= vout_d;
    end
  end

  assign HC_write_ready  = ready_q;
  assign HC_lookup_ready = ready_q;
  assign HC_match        = match_q;
  assign HC_value_out    = vout_q;
  assign HC_full         = full_q;

endmodule

// File: tb/tb_hash_cam_core.sv
// Directed self-checking bench for hash_cam_core at the default INDEX_W=4 (16 slots).
module tb_hash_cam_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic        lk_en = 1'b0;
  logic [15:0] key_in = '0;
  logic [7:0]  value_in = '0;
  logic        wr_rdy, lk_rdy, match, full;
  logic [7:0]  vout;
`ifdef HASHCAM_CLEAR_EN
  logic        clear = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  hash_cam_core #(.INDEX_W(4)) dut (
    .clk             (clk),
    .reset           (reset),
`ifdef HASHCAM_CLEAR_EN
    .HC_clear        (clear),
`endif
    .HC_write_enable (wr_en),
    .HC_write_ready  (wr_rdy),
    .HC_lookup_enable(lk_en),
    .HC_lookup_ready (lk_rdy),
    .HC_key_in       (key_in),
    .HC_value_in     (value_in),
    .HC_match        (match),
    .HC_value_out    (vout),
    .HC_full         (full)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // mode 0 = write, 1 = lookup, 2 = both enables together; low = cycles ready stayed low
  task automatic do_op(input int mode, input logic [15:0] k, input logic [7:0] v, output int low);
    @(negedge clk);
    key_in   = k;
    value_in = v;
    wr_en    = (mode != 1);
    lk_en    = (mode != 0);
    @(posedge clk);
    #1;
    wr_en    = 1'b0;
    lk_en    = 1'b0;
    key_in   = ~k;
    value_in = ~v;
    low = 0;
    @(negedge clk);
    while (wr_rdy === 1'b0 && low < 40) begin
      low++;
      @(negedge clk);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int low;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (wr_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ready: got %b expected 0", wr_rdy); end
    n_checks++; if (lk_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_lk_ready: got %b expected 0", lk_rdy); end
    n_checks++; if (match !== 1'b0) begin n_fail++; $display("FAIL reset_match: got %b expected 0", match); end
    n_checks++; if (vout !== 8'h00) begin n_fail++; $display("FAIL reset_value: got %h expected 00", vout); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (wr_rdy !== 1'b1 || lk_rdy !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %b%b expected 11", wr_rdy, lk_rdy); end
    do_op(1, 16'h1234, 8'h00, low);
    n_checks++; if (match !== 1'b0 || vout !== 8'h00) begin n_fail++; $display("FAIL empty_lookup: got %b/%h expected 0/00", match, vout); end
  endtask

  task automatic test_basic();
    int low;
    apply_reset();
    do_op(0, 16'h1234, 8'hAB, low);
    n_checks++; if (low !== 1) begin n_fail++; $display("FAIL basic_write_low: got %0d expected 1", low); end
    do_op(1, 16'h1234, 8'h00, low);
    n_checks++; if (low !== 1) begin n_fail++; $display("FAIL basic_lookup_low: got %0d expected 1", low); end
    n_checks++; if (match !== 1'b1 || vout !== 8'hAB) begin n_fail++; $display("FAIL basic_hit: got %b/%h expected 1/ab", match, vout); end
    do_op(0, 16'h0001, 8'h3C, low);
    n_checks++; if (match !== 1'b1 || vout !== 8'hAB) begin n_fail++; $display("FAIL hold_after_write: got %b/%h expected 1/ab", match, vout); end
    do_op(1, 16'h0002, 8'h00, low);
    n_checks++; if (low !== 1 || match !== 1'b0 || vout !== 8'h00) begin n_fail++; $display("FAIL miss_empty: got %0d/%b/%h expected 1/0/00", low, match, vout); end
    n_checks++; if (lk_rdy !== 1'b1) begin n_fail++; $display("FAIL lk_ready_idle: got %b expected 1", lk_rdy); end
  endtask

  task automatic test_collision();
    int low;
    apply_reset();
    do_op(0, 16'h1234, 8'h11, low);
    n_checks++; if (low !== 1) begin n_fail++; $display("FAIL coll_w1_low: got %0d expected 1", low); end
    do_op(0, 16'h4000, 8'h22, low);
    n_checks++; if (low !== 2) begin n_fail++; $display("FAIL coll_w2_low: got %0d expected 2", low); end
    do_op(1, 16'h4000, 8'h00, low);
    n_checks++; if (low !== 2 || match !== 1'b1 || vout !== 8'h22) begin n_fail++; $display("FAIL coll_hit: got %0d/%b/%h expected 2/1/22", low, match, vout); end
    do_op(1, 16'h0004, 8'h00, low);
    n_checks++; if (low !== 3 || match !== 1'b0 || vout !== 8'h00) begin n_fail++; $display("FAIL coll_miss: got %0d/%b/%h expected 3/0/00", low, match, vout); end
    do_op(0, 16'h1234, 8'h55, low);
    n_checks++; if (low !== 1) begin n_fail++; $display("FAIL overwrite_low: got %0d expected 1", low); end
    do_op(1, 16'h1234, 8'h00, low);
    n_checks++; if (match !== 1'b1 || vout !== 8'h55) begin n_fail++; $display("FAIL overwrite_hit: got %b/%h expected 1/55", match, vout); end
    do_op(1, 16'h4000, 8'h00, low);
    n_checks++; if (match !== 1'b1 || vout !== 8'h22) begin n_fail++; $display("FAIL overwrite_other: got %b/%h expected 1/22", match, vout); end
  endtask

  task automatic test_wrap();
    int low;
    apply_reset();
    do_op(0, 16'h000F, 8'hA1, low);
    do_op(0, 16'h00F0, 8'hA2, low);
    n_checks++; if (low !== 2) begin n_fail++; $display("FAIL wrap_write_low: got %0d expected 2", low); end
    do_op(1, 16'h00F0, 8'h00, low);
    n_checks++; if (low !== 2 || match !== 1'b1 || vout !== 8'hA2) begin n_fail++; $display("FAIL wrap_hit: got %0d/%b/%h expected 2/1/a2", low, match, vout); end
  endtask

  task automatic test_both_enables();
    int low;
    apply_reset();
    do_op(2, 16'h1234, 8'h66, low);
    n_checks++; if (low !== 1 || match !== 1'b0 || vout !== 8'h00) begin n_fail++; $display("FAIL both_write_wins: got %0d/%b/%h expected 1/0/00", low, match, vout); end
    do_op(1, 16'h1234, 8'h00, low);
    n_checks++; if (match !== 1'b1 || vout !== 8'h66) begin n_fail++; $display("FAIL both_stored: got %b/%h expected 1/66", match, vout); end
  endtask

  task automatic test_full();
    int low;
    apply_reset();
    for (int i = 0; i < 15; i++) begin
      do_op(0, 16'(i), 8'(8'h80 + i), low);
      n_checks++; if (low !== 1) begin n_fail++; $display("FAIL fill_low key %0d: got %0d expected 1", i, low); end
    end
    do_op(0, 16'h0000, 8'h7F, low);
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL full_after_overwrite: got %b expected 0", full); end
    do_op(0, 16'h000F, 8'h8F, low);
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_after_16: got %b expected 1", full); end
    do_op(0, 16'h0010, 8'hEE, low);
    n_checks++; if (low !== 16 || full !== 1'b1) begin n_fail++; $display("FAIL drop_write: got %0d/%b expected 16/1", low, full); end
    do_op(1, 16'h0010, 8'h00, low);
    n_checks++; if (low !== 16 || match !== 1'b0 || vout !== 8'h00) begin n_fail++; $display("FAIL drop_lookup: got %0d/%b/%h expected 16/0/00", low, match, vout); end
    do_op(0, 16'h0005, 8'h5A, low);
    do_op(1, 16'h0005, 8'h00, low);
    n_checks++; if (match !== 1'b1 || vout !== 8'h5A) begin n_fail++; $display("FAIL full_rewrite: got %b/%h expected 1/5a", match, vout); end
    do_op(1, 16'h0000, 8'h00, low);
    n_checks++; if (match !== 1'b1 || vout !== 8'h7F) begin n_fail++; $display("FAIL full_key0: got %b/%h expected 1/7f", match, vout); end
    do_op(1, 16'h000F, 8'h00, low);
    n_checks++; if (match !== 1'b1 || vout !== 8'h8F) begin n_fail++; $display("FAIL full_key15: got %b/%h expected 1/8f", match, vout); end
  endtask

  task automatic test_reset_mid_probe();
    int low;
    apply_reset();
    do_op(0, 16'h1234, 8'h11, low);
    do_op(1, 16'h1234, 8'h00, low);
    @(negedge clk);
    key_in = 16'h4000;
    value_in = 8'h22;
    wr_en = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (wr_rdy !== 1'b0 || lk_rdy !== 1'b0 || match !== 1'b0 || vout !== 8'h00 || full !== 1'b0)
      begin n_fail++; $display("FAIL mid_reset_outputs: got rdy %b%b match %b val %h full %b expected 00/0/00/0", wr_rdy, lk_rdy, match, vout, full); end
    reset = 1'b0;
    @(negedge clk);
    do_op(1, 16'h4000, 8'h00, low);
    n_checks++; if (low !== 1 || match !== 1'b0 || vout !== 8'h00) begin n_fail++; $display("FAIL mid_reset_lookup: got %0d/%b/%h expected 1/0/00", low, match, vout); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_collision();
    test_wrap();
    test_both_enables();
    test_full();
    test_reset_mid_probe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
